// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave with single/quad lanes, oversampled in the pclk domain.
// Received words go to a valid/ready holding register; response words are loaded through a tx_valid/tx_ready strobe.
module spi_slave_responder #(
  parameter int unsigned NO_OF_SLAVES = 4,
  parameter int unsigned SLAVE_ID     = 0,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    sclk,
  input  logic [NO_OF_SLAVES-1:0] cs,
  input  logic                    mosi0,
  input  logic                    mosi1,
  input  logic                    mosi2,
  input  logic                    mosi3,
  output logic                    miso0,
  output logic                    miso1,
  output logic                    miso2,
  output logic                    miso3,
  input  logic                    quad_en,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    busy,
  output logic                    underrun,
  output logic                    overrun,
  input  logic                    err_clr
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_next;
  logic [1:0]            sclk_sync, cs_sync;
  logic                  sclk_d, cs_d;
  logic [3:0]            mosi_s1, mosi_s2;
  logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                  quad_mode;
  logic [CW-1:0]         count, count_sum, step;
  logic [DATA_WIDTH-1:0] tx_shift, load_word, rx_next;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [3:0]            miso_q;
  logic                  tx_load, word_done;
  logic                  cs_unused;

  assign cs_unused = ^cs;

  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      mosi_s1   <= '0;
      mosi_s2   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs[SLAVE_ID]};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      mosi_s1   <= {mosi3, mosi2, mosi1, mosi0};
      mosi_s2   <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;

  always_ff @(posedge pclk) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    word_done  = 1'b0;
    step       = quad_mode ? CW'(4) : CW'(1);
    count_sum  = count + step;
    load_word  = tx_valid ? tx_data : '1;
    rx_next    = quad_mode ? {rx_shift[DATA_WIDTH-5:0], mosi_s2}
                           : {rx_shift[DATA_WIDTH-2:0], mosi_s2[0]};
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          tx_load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else if (sclk_rise && count_sum == CW'(DATA_WIDTH)) begin
          word_done = 1'b1;
          tx_load   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    tx_ready = tx_load & ~areset;
  end

  // tx_shift always holds the bits still to be presented, MSB-aligned; a
  // completion reload is therefore presented unshifted on the following fall.
  always_ff @(posedge pclk) begin
    if (areset) begin
      count     <= '0;
      quad_mode <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      miso_q    <= '0;
    end else begin
      if (err_clr) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end
      if (tx_load && !tx_valid) underrun <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state == IDLE) begin
        count  <= '0;
        miso_q <= '0;
        if (cs_fall) begin
          quad_mode <= quad_en;
          if (quad_en) begin
            miso_q   <= load_word[DATA_WIDTH-1 -: 4];
            tx_shift <= load_word << 4;
          end else begin
            miso_q   <= {3'b000, load_word[DATA_WIDTH-1]};
            tx_shift <= load_word << 1;
          end
        end
      end else if (cs_rise) begin
        count  <= '0;
        miso_q <= '0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_next[DATA_WIDTH-2:0];
          count    <= word_done ? '0 : count_sum;
          if (word_done) begin
            tx_shift <= load_word;
            if (!rx_valid || rx_ready) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        if (sclk_fall) begin
          miso_q   <= quad_mode ? tx_shift[DATA_WIDTH-1 -: 4] : {3'b000, tx_shift[DATA_WIDTH-1]};
          tx_shift <= quad_mode ? tx_shift << 4 : tx_shift << 1;
        end
      end
    end
  end

  assign {miso3, miso2, miso1, miso0} = miso_q;
  assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-level SPI master drives frames while a
// word-level model of the tx feed and rx holding register predicts the results.
module tb_spi_slave_responder;

  localparam int unsigned NS      = 4;
  localparam int unsigned SID     = 2;
  localparam int unsigned FOREIGN = 1;
  localparam int unsigned DW      = 32;

  logic          pclk = 1'b0;
  logic          areset, sclk, quad_en, tx_valid, rx_ready, err_clr;
  logic [NS-1:0] cs;
  logic          mosi0, mosi1, mosi2, mosi3;
  logic          miso0, miso1, miso2, miso3;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_ready, rx_valid, busy, underrun, overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned hs_count;

  logic [31:0] src_q[$];
  logic [31:0] txm[$];
  logic [31:0] mosi_q[$];
  bit          m_rx_valid, m_underrun, m_overrun;
  logic [31:0] m_rx_data;

  always #5 pclk = ~pclk;

  spi_slave_responder #(.NO_OF_SLAVES(NS), .SLAVE_ID(SID), .DATA_WIDTH(DW)) dut (
    .pclk(pclk), .areset(areset), .sclk(sclk), .cs(cs),
    .mosi0(mosi0), .mosi1(mosi1), .mosi2(mosi2), .mosi3(mosi3),
    .miso0(miso0), .miso1(miso1), .miso2(miso2), .miso3(miso3),
    .quad_en(quad_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .underrun(underrun), .overrun(overrun), .err_clr(err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Feed: the last queued word stays offered until a newer one is queued.
  initial begin
    bit hs;
    tx_valid = 1'b0;
    tx_data  = '0;
    hs_count = 0;
    forever begin
      @(negedge pclk);
      hs = tx_ready;
      if (tx_ready) hs_count++;
      @(posedge pclk);
      #1;
      if (hs && src_q.size() > 1) void'(src_q.pop_front());
      tx_valid = (src_q.size() > 0);
      tx_data  = tx_valid ? src_q[0] : '0;
    end
  end

  task automatic feed_clear();
    src_q.delete();
    txm.delete();
  endtask

  task automatic feed_push(input logic [31:0] w);
    src_q.push_back(w);
    txm.push_back(w);
  endtask

  function automatic logic [31:0] model_load();
    logic [31:0] w;
    if (txm.size() == 0) begin
      m_underrun = 1'b1;
      return '1;
    end
    w = txm[0];
    if (txm.size() > 1) void'(txm.pop_front());
    return w;
  endfunction

  task automatic spi_frame(input bit quad, input int unsigned nclk);
    int unsigned cpw, nb, loads, widx, bpu;
    logic [31:0] cur_tx, acc_miso, word_out;
    logic        hi_bits;
    bit          prev;
    bpu = quad ? 4 : 1;
    cpw = 32 / bpu;
    nb = 0; loads = 1; widx = 0; acc_miso = '0; hi_bits = 1'b0; word_out = '0;
    wait_clks(2);
    hs_count = 0;
    cur_tx = model_load();
    quad_en = quad;
    cs[SID] = 1'b0;
    wait_clks(2);
    check_eq("busy_early", busy, 0);
    wait_clks(1);
    check_eq("busy_rise", busy, 1);
    quad_en = ($urandom_range(0, 1) == 1);
    wait_clks(1);
    for (int unsigned k = 0; k < nclk; k++) begin
      if (nb == 0) word_out = (widx < mosi_q.size()) ? mosi_q[widx] : $urandom;
      if (quad) {mosi3, mosi2, mosi1, mosi0} = word_out[31 - 4*nb -: 4];
      else begin
        mosi0 = word_out[31 - nb];
        {mosi3, mosi2, mosi1} = 3'($urandom);
      end
      wait_clks(4);
      if (quad) acc_miso = {acc_miso[27:0], miso3, miso2, miso1, miso0};
      else begin
        acc_miso = {acc_miso[30:0], miso0};
        hi_bits  = hi_bits | miso1 | miso2 | miso3;
      end
      sclk = 1'b1;
      nb++;
      if (nb == cpw) begin
        prev = m_rx_valid;
        wait_clks(2);
        if (!prev) check_eq("rxv_early", rx_valid, 0);
        wait_clks(1);
        check_eq("rxv_rise", rx_valid, 1);
        if (prev) m_overrun = 1'b1;
        else begin
          m_rx_valid = 1'b1;
          m_rx_data  = word_out;
        end
        check_eq("rx_data", rx_data, m_rx_data);
        check_eq("miso_word", acc_miso, cur_tx);
        cur_tx = model_load();
        loads++; widx++; nb = 0; acc_miso = '0;
        wait_clks(1);
      end else begin
        wait_clks(4);
      end
      sclk = 1'b0;
    end
    if (nb != 0) check_eq("miso_part", acc_miso, cur_tx >> (32 - nb*bpu));
    check_eq("rxv_hold", rx_valid, m_rx_valid);
    wait_clks(4);
    cs[SID] = 1'b1;
    {mosi3, mosi2, mosi1, mosi0} = 4'h0;
    wait_clks(2);
    check_eq("busy_hold", busy, 1);
    wait_clks(1);
    check_eq("busy_fall", busy, 0);
    if (!quad) check_eq("miso_hi", hi_bits, 0);
    check_eq("miso_idle", {miso3, miso2, miso1, miso0}, 0);
    check_eq("tx_loads", hs_count, loads);
    check_eq("underrun", underrun, m_underrun);
    check_eq("overrun", overrun, m_overrun);
    mosi_q.delete();
  endtask

  task automatic rx_pop();
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    m_rx_valid = 1'b0;
    check_eq("rx_pop", rx_valid, 0);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    m_underrun = 1'b0;
    m_overrun  = 1'b0;
    check_eq("clr_under", underrun, 0);
    check_eq("clr_over", overrun, 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_miso", {miso3, miso2, miso1, miso0}, 0);
    check_eq("rst_txr", tx_ready, 0);
    check_eq("rst_rxd", rx_data, 0);
    check_eq("rst_rxv", rx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_under", underrun, 0);
    check_eq("rst_over", overrun, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          q;
    int unsigned nw, extra;
    areset = 1'b1; sclk = 1'b0; cs = '1; quad_en = 1'b0;
    {mosi3, mosi2, mosi1, mosi0} = 4'h0;
    rx_ready = 1'b0; err_clr = 1'b0;
    m_rx_valid = 1'b0; m_underrun = 1'b0; m_overrun = 1'b0; m_rx_data = '0;
    wait_clks(4);
    check_reset_outputs();
    areset = 1'b0;
    wait_clks(2);

    feed_clear(); feed_push(32'h12345678);
    mosi_q.push_back(32'hA5A50F0F);
    spi_frame(1'b0, 32);
    rx_pop();

    feed_clear(); feed_push(32'hCAFEF00D);
    mosi_q.push_back(32'hDEADBEEF);
    spi_frame(1'b1, 8);
    rx_pop();

    feed_clear();
    spi_frame(1'b0, 32);
    clr_err();
    rx_pop();

    feed_clear(); feed_push(32'h0F0F1234); feed_push(32'h5555AAAA);
    mosi_q.push_back(32'h11111111); mosi_q.push_back(32'h22222222);
    spi_frame(1'b0, 64);
    rx_pop();
    clr_err();

    spi_frame(1'b0, 13);
    mosi_q.push_back(32'h0000FFFF);
    spi_frame(1'b0, 32);
    rx_pop();

    // Leave rx_valid and underrun set, start another frame, reset in mid-frame.
    feed_clear();
    spi_frame(1'b0, 32);
    feed_push($urandom);
    cs[SID] = 1'b0; cs[FOREIGN] = 1'b0;
    wait_clks(8);
    for (int unsigned k = 0; k < 5; k++) begin
      mosi0 = $urandom_range(0, 1);
      wait_clks(4); sclk = 1'b1;
      wait_clks(4); sclk = 1'b0;
    end
    areset = 1'b1; cs[FOREIGN] = 1'b1;
    wait_clks(1);
    check_reset_outputs();
    m_rx_valid = 1'b0; m_rx_data = '0; m_underrun = 1'b0; m_overrun = 1'b0;
    wait_clks(2);
    areset = 1'b0; cs[SID] = 1'b1;
    wait_clks(4);
    hs_count = 0;
    cs[FOREIGN] = 1'b0;
    wait_clks(8);
    for (int unsigned k = 0; k < 8; k++) begin
      mosi0 = $urandom_range(0, 1);
      wait_clks(4); sclk = 1'b1;
      wait_clks(4); sclk = 1'b0;
    end
    cs[FOREIGN] = 1'b1;
    wait_clks(4);
    check_eq("fgn_busy", busy, 0);
    check_eq("fgn_loads", hs_count, 0);
    check_eq("fgn_rxv", rx_valid, 0);
    check_eq("fgn_miso", {miso3, miso2, miso1, miso0}, 0);

    for (int unsigned it = 0; it < 10; it++) begin
      q     = ($urandom_range(0, 1) == 1);
      nw    = $urandom_range(1, 2);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (q ? 8 : 32) - 1) : 0;
      feed_clear();
      for (int unsigned j = $urandom_range(0, 2); j > 0; j--) feed_push($urandom);
      for (int unsigned j = 0; j < nw; j++) mosi_q.push_back($urandom);
      spi_frame(q, nw * (q ? 8 : 32) + extra);
      if (m_rx_valid) rx_pop();
      if (m_underrun || m_overrun) clr_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
